// File: rtl/fifo_flags.sv
// fifo_flags: single-clock synchronous FIFO with occupancy count, level
// flags and sticky overflow/underflow error flags.
//
// Storage is a plain flop array of DEPTH words. DEPTH need not be a power
// of two, so both pointers wrap by comparing against DEPTH-1 instead of
// relying on binary roll-over. All status flags are decoded from the
// registered occupancy count, which keeps them glitch-free with respect to
// push/pop and gives a single source of truth for "how full am I".
//
// Read modes:
//   FWFT = 0 : Dout is a register loaded with the head word on each
//              accepted pop; it holds otherwise.
//   FWFT = 1 : Dout shows the head word combinationally while the FIFO is
//              non-empty and is forced to zero when empty, so a stale word
//              left in storage is never visible.
module fifo_flags #(
  parameter int DEPTH  = 16,
  parameter int BITS   = 16,
  parameter int FWFT   = 0,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BITS-1:0]            Din,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clr_err,
  output logic [BITS-1:0]            Dout,
  output logic                       pndng,
  output logic                       full,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf,
  output logic                       udf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Constants sized to the signals they are compared against.
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_LVL);
  localparam logic [CW-1:0] AE_C     = CW'(AE_LVL);

  logic [BITS-1:0] mem [DEPTH];

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr_nxt;
  logic [PW-1:0]   rd_ptr_nxt;

  logic            push_ok;
  logic            pop_ok;
  logic            ovf_set;
  logic            udf_set;
  logic [BITS-1:0] head;

  // ------------------------------------------------------------------
  // Status decode from the registered count
  // ------------------------------------------------------------------
  assign pndng        = (count != '0);
  assign full         = (count == DEPTH_C);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // ------------------------------------------------------------------
  // Request qualification
  // ------------------------------------------------------------------
  // A pop needs something to read. A push needs room, or a pop in the same
  // cycle freeing the slot it will land in. When empty, pndng is low, so
  // a simultaneous pop is rejected and the push alone goes through.
  assign pop_ok  = pop & pndng;
  assign push_ok = push & (~full | pop_ok);

  // Errors are raised for requests that were made but not honoured.
  assign ovf_set = push & ~push_ok;
  assign udf_set = pop & ~pndng;

  // Explicit wrap at DEPTH-1 so non-power-of-two depths work.
  assign wr_ptr_nxt = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
  assign rd_ptr_nxt = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;

  assign head = mem[rd_ptr];

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= Din;
    end
  end

  // Write pointer advances on each accepted push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
    end else if (push_ok) begin
      wr_ptr <= wr_ptr_nxt;
    end
  end

  // Read pointer advances on each accepted pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
    end else if (pop_ok) begin
      rd_ptr <= rd_ptr_nxt;
    end
  end

  // Occupancy: +1 push only, -1 pop only, unchanged for both or neither.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag; a new error in the clearing cycle wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (ovf_set) begin
      ovf <= 1'b1;
    end else if (clr_err) begin
      ovf <= 1'b0;
    end
  end

  // Sticky underflow flag; a new error in the clearing cycle wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      udf <= 1'b0;
    end else if (udf_set) begin
      udf <= 1'b1;
    end else if (clr_err) begin
      udf <= 1'b0;
    end
  end

  // ------------------------------------------------------------------
  // Read data path
  // ------------------------------------------------------------------
  if (FWFT != 0) begin : g_fwft
    // Gate with pndng: after reset the array may still hold old words.
    assign Dout = pndng ? head : '0;
  end else begin : g_reg
    logic [BITS-1:0] dout_q;

    // Capture the head word on each accepted pop, hold otherwise.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        dout_q <= '0;
      end else if (pop_ok) begin
        dout_q <= head;
      end
    end

    assign Dout = dout_q;
  end

endmodule

// File: tb/tb_fifo_flags.sv
// tb_fifo_flags: directed bench for fifo_flags. Instance u_reg uses the
// registered read mode, u_fwft the first-word-fall-through mode; both are
// DEPTH=16, BITS=16 with default thresholds (almost_full at 14, almost_empty
// at 2). Inputs change 1 ns after a rising edge and outputs are sampled at
// the same point, i.e. well away from the active edge.
module tb_fifo_flags;

  logic        clk;
  logic        rst;

  logic [15:0] din0, dout0;
  logic        push0, pop0, clr0;
  logic        pndng0, full0, af0, ae0, ovf0, udf0;
  logic [4:0]  cnt0;

  logic [15:0] din1, dout1;
  logic        push1, pop1, clr1;
  logic        pndng1, full1, af1, ae1, ovf1, udf1;
  logic [4:0]  cnt1;

  int passed;
  int total;

  fifo_flags #(.DEPTH(16), .BITS(16), .FWFT(0)) u_reg (
    .clk(clk), .rst(rst), .Din(din0), .push(push0), .pop(pop0),
    .clr_err(clr0), .Dout(dout0), .pndng(pndng0), .full(full0),
    .almost_full(af0), .almost_empty(ae0), .count(cnt0),
    .ovf(ovf0), .udf(udf0)
  );

  fifo_flags #(.DEPTH(16), .BITS(16), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .Din(din1), .push(push1), .pop(pop1),
    .clr_err(clr1), .Dout(dout1), .pndng(pndng1), .full(full1),
    .almost_full(af1), .almost_empty(ae1), .count(cnt1),
    .ovf(ovf1), .udf(udf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    push0 = 1'b0; pop0 = 1'b0; clr0 = 1'b0; din0 = '0;
    push1 = 1'b0; pop1 = 1'b0; clr1 = 1'b0; din1 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    #2 rst = 1'b0;
    #2 rst = 1'b1;
  endtask

  task automatic fill0(input logic [15:0] base);
    push0 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din0 = base + 16'(i);
      tick();
    end
    push0 = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #1;
    total++; if (dout0 !== 16'h0) $display("FAIL rst_dout got %h want 0000", dout0); else passed++;
    total++; if (cnt0 !== 5'd0) $display("FAIL rst_count got %0d want 0", cnt0); else passed++;
    total++; if (pndng0 !== 1'b0) $display("FAIL rst_pndng got %b want 0", pndng0); else passed++;
    total++; if (full0 !== 1'b0) $display("FAIL rst_full got %b want 0", full0); else passed++;
    total++; if (af0 !== 1'b0) $display("FAIL rst_af got %b want 0", af0); else passed++;
    total++; if (ae0 !== 1'b1) $display("FAIL rst_ae got %b want 1", ae0); else passed++;
    total++; if (ovf0 !== 1'b0 || udf0 !== 1'b0) $display("FAIL rst_err got %b%b want 00", ovf0, udf0); else passed++;
    total++; if (dout1 !== 16'h0 || pndng1 !== 1'b0) $display("FAIL rst_fwft got %h/%b want 0000/0", dout1, pndng1); else passed++;
    #2 rst = 1'b1;
  endtask

  task automatic test_fill_drain();
    do_reset();
    push0 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din0 = 16'(i);
      tick();
      total++; if (cnt0 !== 5'(i + 1)) $display("FAIL fill_count[%0d] got %0d want %0d", i, cnt0, i + 1); else passed++;
      total++; if (af0 !== ((i + 1) >= 14)) $display("FAIL fill_af[%0d] got %b want %b", i, af0, (i + 1) >= 14); else passed++;
      total++; if (ae0 !== ((i + 1) <= 2)) $display("FAIL fill_ae[%0d] got %b want %b", i, ae0, (i + 1) <= 2); else passed++;
      total++; if (full0 !== (i == 15)) $display("FAIL fill_full[%0d] got %b want %b", i, full0, i == 15); else passed++;
    end
    push0 = 1'b0;
    pop0  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      total++; if (dout0 !== 16'(i)) $display("FAIL drain_dout[%0d] got %h want %h", i, dout0, 16'(i)); else passed++;
      total++; if (cnt0 !== 5'(15 - i)) $display("FAIL drain_count[%0d] got %0d want %0d", i, cnt0, 15 - i); else passed++;
      total++; if (ae0 !== ((15 - i) <= 2)) $display("FAIL drain_ae[%0d] got %b want %b", i, ae0, (15 - i) <= 2); else passed++;
    end
    pop0 = 1'b0;
    total++; if (pndng0 !== 1'b0) $display("FAIL drain_pndng got %b want 0", pndng0); else passed++;
    total++; if (udf0 !== 1'b0) $display("FAIL drain_udf got %b want 0", udf0); else passed++;
  endtask

  task automatic test_overflow();
    do_reset();
    fill0(16'h0000);
    push0 = 1'b1;
    for (int k = 0; k < 24; k++) begin
      din0 = 16'h0100 + 16'(k);
      tick();
      total++; if (cnt0 !== 5'd16) $display("FAIL ovf_count[%0d] got %0d want 16", k, cnt0); else passed++;
    end
    total++; if (ovf0 !== 1'b1) $display("FAIL ovf_set got %b want 1", ovf0); else passed++;
    // Clear and a fresh overflow in the same cycle: set must win.
    din0 = 16'h01FF;
    clr0 = 1'b1;
    tick();
    total++; if (ovf0 !== 1'b1) $display("FAIL ovf_set_priority got %b want 1", ovf0); else passed++;
    push0 = 1'b0;
    tick();
    clr0 = 1'b0;
    total++; if (ovf0 !== 1'b0) $display("FAIL ovf_clear got %b want 0", ovf0); else passed++;
    pop0 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      total++; if (dout0 !== 16'(i)) $display("FAIL ovf_drain[%0d] got %h want %h", i, dout0, 16'(i)); else passed++;
    end
    pop0 = 1'b0;
    total++; if (cnt0 !== 5'd0) $display("FAIL ovf_final_count got %0d want 0", cnt0); else passed++;
  endtask

  task automatic test_underflow();
    do_reset();
    pop0 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      total++; if (dout0 !== 16'h0) $display("FAIL udf_dout[%0d] got %h want 0000", k, dout0); else passed++;
      total++; if (cnt0 !== 5'd0) $display("FAIL udf_count[%0d] got %0d want 0", k, cnt0); else passed++;
    end
    pop0 = 1'b0;
    total++; if (udf0 !== 1'b1) $display("FAIL udf_set got %b want 1", udf0); else passed++;
    total++; if (ovf0 !== 1'b0) $display("FAIL udf_ovf got %b want 0", ovf0); else passed++;
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    total++; if (udf0 !== 1'b0) $display("FAIL udf_clear got %b want 0", udf0); else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    push0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din0 = 16'h0200 + 16'(i);
      tick();
    end
    pop0 = 1'b1;
    for (int k = 0; k < 17; k++) begin
      din0 = 16'h0208 + 16'(k);
      tick();
      total++; if (cnt0 !== 5'd8) $display("FAIL b2b_count[%0d] got %0d want 8", k, cnt0); else passed++;
      total++; if (dout0 !== 16'h0200 + 16'(k)) $display("FAIL b2b_dout[%0d] got %h want %h", k, dout0, 16'h0200 + 16'(k)); else passed++;
    end
    push0 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      total++; if (dout0 !== 16'h0211 + 16'(k)) $display("FAIL b2b_drain[%0d] got %h want %h", k, dout0, 16'h0211 + 16'(k)); else passed++;
    end
    total++; if (ovf0 !== 1'b0 || udf0 !== 1'b0) $display("FAIL b2b_err got %b%b want 00", ovf0, udf0); else passed++;
    // Push and pop while empty: push wins, pop is an underflow.
    push0 = 1'b1;
    din0  = 16'h0300;
    tick();
    total++; if (cnt0 !== 5'd1) $display("FAIL b2b_empty_count got %0d want 1", cnt0); else passed++;
    total++; if (udf0 !== 1'b1) $display("FAIL b2b_empty_udf got %b want 1", udf0); else passed++;
    total++; if (dout0 !== 16'h0218) $display("FAIL b2b_empty_hold got %h want 0218", dout0); else passed++;
    push0 = 1'b0;
    tick();
    pop0 = 1'b0;
    total++; if (dout0 !== 16'h0300) $display("FAIL b2b_empty_pop got %h want 0300", dout0); else passed++;
  endtask

  task automatic test_full_push_pop();
    do_reset();
    fill0(16'h0000);
    push0 = 1'b1;
    pop0  = 1'b1;
    din0  = 16'h0077;
    tick();
    push0 = 1'b0;
    total++; if (cnt0 !== 5'd16 || full0 !== 1'b1) $display("FAIL fullpp_count got %0d/%b want 16/1", cnt0, full0); else passed++;
    total++; if (ovf0 !== 1'b0) $display("FAIL fullpp_ovf got %b want 0", ovf0); else passed++;
    total++; if (dout0 !== 16'h0000) $display("FAIL fullpp_dout got %h want 0000", dout0); else passed++;
    for (int i = 1; i < 17; i++) begin
      tick();
      total++; if (dout0 !== ((i == 16) ? 16'h0077 : 16'(i))) $display("FAIL fullpp_drain[%0d] got %h want %h", i, dout0, (i == 16) ? 16'h0077 : 16'(i)); else passed++;
    end
    pop0 = 1'b0;
  endtask

  task automatic test_fwft();
    do_reset();
    tick();
    total++; if (dout1 !== 16'h0) $display("FAIL fwft_empty got %h want 0000", dout1); else passed++;
    push1 = 1'b1;
    din1  = 16'hA5A5;
    tick();
    push1 = 1'b0;
    total++; if (dout1 !== 16'hA5A5 || pndng1 !== 1'b1) $display("FAIL fwft_show got %h/%b want a5a5/1", dout1, pndng1); else passed++;
    pop1 = 1'b1;
    tick();
    pop1 = 1'b0;
    total++; if (dout1 !== 16'h0 || pndng1 !== 1'b0) $display("FAIL fwft_pop got %h/%b want 0000/0", dout1, pndng1); else passed++;
    push1 = 1'b1;
    din1  = 16'h1234;
    tick();
    din1  = 16'h5A5A;
    tick();
    push1 = 1'b0;
    total++; if (dout1 !== 16'h1234 || cnt1 !== 5'd2) $display("FAIL fwft_head got %h/%0d want 1234/2", dout1, cnt1); else passed++;
    pop1 = 1'b1;
    tick();
    total++; if (dout1 !== 16'h5A5A) $display("FAIL fwft_next got %h want 5a5a", dout1); else passed++;
    tick();
    pop1 = 1'b0;
    total++; if (dout1 !== 16'h0 || udf1 !== 1'b0) $display("FAIL fwft_drained got %h/%b want 0000/0", dout1, udf1); else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    push0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      din0 = 16'h0040 + 16'(i);
      tick();
    end
    push0 = 1'b0;
    pop0  = 1'b1;
    tick();
    pop0  = 1'b0;
    total++; if (dout0 !== 16'h0040 || cnt0 !== 5'd5) $display("FAIL arst_pre got %h/%0d want 0040/5", dout0, cnt0); else passed++;
    #2 rst = 1'b0;
    #1;
    total++; if (cnt0 !== 5'd0 || pndng0 !== 1'b0) $display("FAIL arst_count got %0d/%b want 0/0", cnt0, pndng0); else passed++;
    total++; if (dout0 !== 16'h0) $display("FAIL arst_dout got %h want 0000", dout0); else passed++;
    total++; if (ae0 !== 1'b1 || af0 !== 1'b0 || full0 !== 1'b0) $display("FAIL arst_flags got ae%b af%b f%b want ae1 af0 f0", ae0, af0, full0); else passed++;
    #1 rst = 1'b1;
    push0 = 1'b1;
    din0  = 16'h0011;
    tick();
    push0 = 1'b0;
    total++; if (cnt0 !== 5'd1) $display("FAIL arst_after_count got %0d want 1", cnt0); else passed++;
    pop0 = 1'b1;
    tick();
    pop0 = 1'b0;
    total++; if (dout0 !== 16'h0011) $display("FAIL arst_after_dout got %h want 0011", dout0); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b0;
    idle_inputs();
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_full_push_pop();
    test_fwft();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fifo_flags.md
FIFO_FLAGS -- requirements
Module: fifo_flags

Interface
REQ-001 Parameter DEPTH, default 16, number of storage entries; legal values are 2 to 256, not restricted to powers of two.
REQ-002 Parameter BITS, default 16, data word width.
REQ-003 Parameter FWFT, default 0, read mode: 0 = registered-read, 1 = first-word-fall-through.
REQ-004 Parameter AF_LVL, default DEPTH-2, almost-full threshold in entries.
REQ-005 Parameter AE_LVL, default 2, almost-empty threshold in entries.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 Din  input  BITS  write data.
REQ-009 push  input  1  write request.
REQ-010 pop  input  1  read request.
REQ-011 clr_err  input  1  synchronous clear of the sticky error flags.
REQ-012 Dout  output  BITS  read data.
REQ-013 pndng  output  1  FIFO is not empty (count != 0).
REQ-014 full  output  1  count == DEPTH.
REQ-015 almost_full  output  1  count >= AF_LVL.
REQ-016 almost_empty  output  1  count <= AE_LVL.
REQ-017 count  output  $clog2(DEPTH+1)  current occupancy.
REQ-018 ovf  output  1  sticky flag: push was attempted while full and not accepted.
REQ-019 udf  output  1  sticky flag: pop was attempted while empty.

Function
REQ-020 Storage SHALL be a flop array of DEPTH words, addressed by write and read pointers of width $clog2(DEPTH).
REQ-021 Each pointer SHALL wrap from DEPTH-1 to 0 by explicit compare, not by modulo-2^n overflow.
REQ-022 A push SHALL be accepted when !full, or when full and a pop is accepted in the same cycle; an accepted push writes Din at the write pointer and advances it.
REQ-023 A pop SHALL be accepted only when pndng == 1; an accepted pop advances the read pointer.
REQ-024 count SHALL update on each edge: +1 for push only, -1 for pop only, unchanged for both accepted or neither.
REQ-025 full, pndng, almost_full and almost_empty SHALL be decoded combinationally from the registered count.
REQ-026 FWFT=0: on an accepted pop, Dout SHALL register the head word, valid on the cycle after the pop edge; otherwise Dout SHALL hold its value.
REQ-027 FWFT=1: Dout SHALL show the head word combinationally whenever pndng == 1, and 0 when empty; a pop SHALL consume the displayed word.
REQ-028 Push and pop both asserted while empty: the push SHALL be accepted, the pop SHALL be rejected, udf SHALL be set, and count SHALL go 0 -> 1.
REQ-029 Push and pop both asserted while full: both SHALL be accepted, count SHALL stay DEPTH, and ovf SHALL not be set.
REQ-030 A rejected push SHALL not modify storage, pointers or count, and SHALL set ovf on that edge.
REQ-031 ovf and udf SHALL remain set until clr_err or reset.
REQ-032 clr_err SHALL clear both flags on the edge; if a new error occurs in the same cycle, set SHALL take priority over clear.
REQ-033 Latency: a word pushed into an empty FIFO SHALL raise pndng one cycle after the push edge; with FWFT=1 it SHALL appear on Dout in that same cycle.

Reset
REQ-034 rst low SHALL immediately, without waiting for a clock edge, force: pointers 0, count 0, Dout 0, pndng 0, full 0, almost_full 0, almost_empty 1, ovf 0, udf 0.
REQ-035 Storage contents SHALL not be reset; no stale word SHALL be observable on Dout after reset.
REQ-036 Reset asserted mid-operation SHALL discard all queued data; the first pop after reset release SHALL return the first word pushed after release.
REQ-037 Reset release SHALL take effect at the next rising edge; push and pop presented on that edge SHALL be honoured.

Verification
REQ-038 Fill/drain, DEPTH=16, FWFT=0: push 0..15 -> full=1 and count=16 after the 16th edge; 16 pops -> Dout sequence 0..15, then pndng=0 and almost_empty=1.
REQ-039 Overflow: from full, push 24 more words -> ovf=1, count stays 16, drained data is 0..15; clr_err -> ovf=0.
REQ-040 Underflow: from reset, pop 20 times -> udf=1, count=0, Dout=0 throughout.
REQ-041 Simultaneous push and pop: at count=8, 17 cycles of push+pop -> count stays 8 and output order matches input order across pointer wrap; the same at count=0 -> count=1 and udf=1.
REQ-042 FWFT=1: push 0xA5A5 into an empty FIFO -> Dout=0xA5A5 and pndng=1 on the next cycle; pop -> Dout=0 and pndng=0.
REQ-043 Async reset: assert rst low between clock edges at count=5 -> all outputs take their reset values before the next edge; push 0x0011 after release, then pop -> Dout=0x0011.
